// File: rtl/wisc_pkg.sv
// Shared WISC-SP13 definitions: datapath width defaults, opcode encodings, control bundle.
// Used by id_ex_stage and fwd_mux (behaviour selectable with ID_EX_FWD_EN).
package wisc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int RIDX_W_DEF = 3;
  localparam int OP_W_DEF   = 5;
  localparam int IMM_W_DEF  = 8;

  localparam logic [OP_W_DEF-1:0] OP_HALT  = 5'b00000;
  localparam logic [OP_W_DEF-1:0] OP_NOP   = 5'b00001;
  localparam logic [OP_W_DEF-1:0] OP_ADDI  = 5'b01000;
  localparam logic [OP_W_DEF-1:0] OP_SUBI  = 5'b01001;
  localparam logic [OP_W_DEF-1:0] OP_ST    = 5'b10000;
  localparam logic [OP_W_DEF-1:0] OP_LD    = 5'b10001;
  localparam logic [OP_W_DEF-1:0] OP_ALU_R = 5'b11011;

  // Control bits that travel with the instruction into EX/MEM
  typedef struct packed {
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand selector for one ALU source: EX/MEM result, then MEM/WB value, then latched value.
// With ID_EX_FWD_EN undefined the latched value passes straight through.
module fwd_mux
  import wisc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RIDX_W = RIDX_W_DEF
) (
  input  logic [RIDX_W-1:0] i_idx,
  input  logic              i_used,
  input  logic [DATA_W-1:0] i_latched,
  input  logic              i_exm_reg_wr,
  input  logic              i_exm_mem_rd,
  input  logic [RIDX_W-1:0] i_exm_rd_idx,
  input  logic [DATA_W-1:0] i_exm_res,
  input  logic              i_wb_reg_wr,
  input  logic [RIDX_W-1:0] i_wb_rd_idx,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_operand
);

`ifdef ID_EX_FWD_EN
  logic w_exm_hit;
  logic w_wb_hit;

  // A load in EX/MEM has no data yet; the load-use bubble guarantees it is never needed here
  assign w_exm_hit = i_used && i_exm_reg_wr && !i_exm_mem_rd && (i_idx == i_exm_rd_idx);
  assign w_wb_hit  = i_used && i_wb_reg_wr && (i_idx == i_wb_rd_idx);

  always_comb begin
    o_operand = i_latched;
    if (w_exm_hit) begin
      o_operand = i_exm_res;
    end else if (w_wb_hit) begin
      o_operand = i_wb_data;
    end
  end
`else
  logic w_unused_fwd;

  assign w_unused_fwd = ^{i_idx, i_used, i_exm_reg_wr, i_exm_mem_rd, i_exm_rd_idx,
                          i_exm_res, i_wb_reg_wr, i_wb_rd_idx, i_wb_data};
  assign o_operand    = i_latched;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, load-use detection and operand forwarding.
// ID_EX_FWD_EN selects forwarding; without it every RAW dependence stalls until writeback.
module id_ex_stage
  import wisc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RIDX_W = RIDX_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int IMM_W  = IMM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [OP_W-1:0]   i_id_opcode,
  input  logic [1:0]        i_id_funct,
  input  logic [RIDX_W-1:0] i_id_rs_idx,
  input  logic [RIDX_W-1:0] i_id_rt_idx,
  input  logic [RIDX_W-1:0] i_id_rd_idx,
  input  logic              i_id_rs_used,
  input  logic              i_id_rt_used,
  input  logic [DATA_W-1:0] i_id_rs_data,
  input  logic [DATA_W-1:0] i_id_rt_data,
  input  logic [DATA_W-1:0] i_id_pc,
  input  logic [IMM_W-1:0]  i_id_imm,
  input  logic              i_id_reg_wr,
  input  logic              i_id_mem_rd,
  input  logic              i_id_mem_wr,
  input  logic              i_exm_reg_wr,
  input  logic [RIDX_W-1:0] i_exm_rd_idx,
  input  logic [DATA_W-1:0] i_exm_res,
  input  logic              i_exm_mem_rd,
  input  logic              i_wb_reg_wr,
  input  logic [RIDX_W-1:0] i_wb_rd_idx,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_hazard_stall,
  output logic              o_ex_valid,
  output logic [OP_W-1:0]   o_ex_opcode,
  output logic [1:0]        o_ex_funct,
  output logic [DATA_W-1:0] o_ex_pc,
  output logic [IMM_W-1:0]  o_ex_imm,
  output logic [DATA_W-1:0] o_ex_rs,
  output logic [DATA_W-1:0] o_ex_rt,
  output logic [RIDX_W-1:0] o_ex_rd_idx,
  output logic              o_ex_reg_wr,
  output logic              o_ex_mem_rd,
  output logic              o_ex_mem_wr
);

  logic              r_valid;
  logic [OP_W-1:0]   r_opcode;
  logic [1:0]        r_funct;
  logic [DATA_W-1:0] r_pc;
  logic [IMM_W-1:0]  r_imm;
  logic [RIDX_W-1:0] r_rs_idx;
  logic [RIDX_W-1:0] r_rt_idx;
  logic [RIDX_W-1:0] r_rd_idx;
  logic              r_rs_used;
  logic              r_rt_used;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  ctrl_t             r_ctrl;

  logic              w_rs_ex;
  logic              w_rt_ex;
  logic              w_load_use;
  logic              w_raw;
  logic              w_bubble;
  logic [DATA_W-1:0] w_rs_wt;
  logic [DATA_W-1:0] w_rt_wt;

  assign w_rs_ex    = i_id_rs_used && (i_id_rs_idx == r_rd_idx);
  assign w_rt_ex    = i_id_rt_used && (i_id_rt_idx == r_rd_idx);
  assign w_load_use = r_valid && r_ctrl.mem_rd && (w_rs_ex || w_rt_ex);

`ifdef ID_EX_FWD_EN
  assign w_raw = w_load_use;
`else
  logic w_exm_dep;
  logic w_wb_dep;

  assign w_exm_dep = i_exm_reg_wr && ((i_id_rs_used && (i_id_rs_idx == i_exm_rd_idx)) ||
                                      (i_id_rt_used && (i_id_rt_idx == i_exm_rd_idx)));
  assign w_wb_dep  = i_wb_reg_wr && ((i_id_rs_used && (i_id_rs_idx == i_wb_rd_idx)) ||
                                     (i_id_rt_used && (i_id_rt_idx == i_wb_rd_idx)));
  assign w_raw     = w_load_use || (r_ctrl.reg_wr && (w_rs_ex || w_rt_ex)) || w_exm_dep || w_wb_dep;
`endif

  assign o_hazard_stall = w_raw && i_id_valid && !i_flush;
  assign w_bubble       = i_flush || (!i_stall && o_hazard_stall);

  // Register file writes and reads in the same cycle: take the value being written
  assign w_rs_wt = (i_wb_reg_wr && (i_wb_rd_idx == i_id_rs_idx)) ? i_wb_data : i_id_rs_data;
  assign w_rt_wt = (i_wb_reg_wr && (i_wb_rd_idx == i_id_rt_idx)) ? i_wb_data : i_id_rt_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_opcode  <= OP_W'(OP_NOP);
      r_funct   <= '0;
      r_pc      <= '0;
      r_imm     <= '0;
      r_rs_idx  <= '0;
      r_rt_idx  <= '0;
      r_rd_idx  <= '0;
      r_rs_used <= 1'b0;
      r_rt_used <= 1'b0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_ctrl    <= '0;
    end else if (w_bubble) begin
      r_valid  <= 1'b0;
      r_opcode <= OP_W'(OP_NOP);
      r_ctrl   <= '0;
    end else if (!i_stall) begin
      r_valid   <= i_id_valid;
      r_opcode  <= i_id_opcode;
      r_funct   <= i_id_funct;
      r_pc      <= i_id_pc;
      r_imm     <= i_id_imm;
      r_rs_idx  <= i_id_rs_idx;
      r_rt_idx  <= i_id_rt_idx;
      r_rd_idx  <= i_id_rd_idx;
      r_rs_used <= i_id_rs_used;
      r_rt_used <= i_id_rt_used;
      r_rs_data <= w_rs_wt;
      r_rt_data <= w_rt_wt;
      r_ctrl    <= '{reg_wr: i_id_reg_wr, mem_rd: i_id_mem_rd, mem_wr: i_id_mem_wr};
    end
  end

  logic [RIDX_W-1:0] w_src_idx  [2];
  logic              w_src_used [2];
  logic [DATA_W-1:0] w_src_lat  [2];
  logic [DATA_W-1:0] w_src_op   [2];

  assign w_src_idx[0]  = r_rs_idx;
  assign w_src_idx[1]  = r_rt_idx;
  assign w_src_used[0] = r_rs_used;
  assign w_src_used[1] = r_rt_used;
  assign w_src_lat[0]  = r_rs_data;
  assign w_src_lat[1]  = r_rt_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_mux #(
        .DATA_W(DATA_W),
        .RIDX_W(RIDX_W)
      ) u_fwd (
        .i_idx        (w_src_idx[gi]),
        .i_used       (w_src_used[gi]),
        .i_latched    (w_src_lat[gi]),
        .i_exm_reg_wr (i_exm_reg_wr),
        .i_exm_mem_rd (i_exm_mem_rd),
        .i_exm_rd_idx (i_exm_rd_idx),
        .i_exm_res    (i_exm_res),
        .i_wb_reg_wr  (i_wb_reg_wr),
        .i_wb_rd_idx  (i_wb_rd_idx),
        .i_wb_data    (i_wb_data),
        .o_operand    (w_src_op[gi])
      );
    end
  endgenerate

  assign o_ex_valid  = r_valid;
  assign o_ex_opcode = r_opcode;
  assign o_ex_funct  = r_funct;
  assign o_ex_pc     = r_pc;
  assign o_ex_imm    = r_imm;
  assign o_ex_rs     = w_src_op[0];
  assign o_ex_rt     = w_src_op[1];
  assign o_ex_rd_idx = r_rd_idx;
  assign o_ex_reg_wr = r_ctrl.reg_wr;
  assign o_ex_mem_rd = r_ctrl.mem_rd;
  assign o_ex_mem_wr = r_ctrl.mem_wr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver predicts the EX slot after every edge and queues it,
// a monitor pops and compares after each edge. Follows ID_EX_FWD_EN like the design.
module tb_id_ex_stage;
  import wisc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall, flush, id_valid;
  logic [4:0]  id_opcode;
  logic [1:0]  id_funct;
  logic [2:0]  id_rs_idx, id_rt_idx, id_rd_idx;
  logic        id_rs_used, id_rt_used;
  logic [15:0] id_rs_data, id_rt_data, id_pc;
  logic [7:0]  id_imm;
  logic        id_reg_wr, id_mem_rd, id_mem_wr;
  logic        exm_reg_wr, exm_mem_rd, wb_reg_wr;
  logic [2:0]  exm_rd_idx, wb_rd_idx;
  logic [15:0] exm_res, wb_data;

  logic        hazard_stall, ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr;
  logic [4:0]  ex_opcode;
  logic [1:0]  ex_funct;
  logic [15:0] ex_pc, ex_rs, ex_rt;
  logic [7:0]  ex_imm;
  logic [2:0]  ex_rd_idx;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush), .i_id_valid(id_valid),
    .i_id_opcode(id_opcode), .i_id_funct(id_funct), .i_id_rs_idx(id_rs_idx),
    .i_id_rt_idx(id_rt_idx), .i_id_rd_idx(id_rd_idx), .i_id_rs_used(id_rs_used),
    .i_id_rt_used(id_rt_used), .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data),
    .i_id_pc(id_pc), .i_id_imm(id_imm), .i_id_reg_wr(id_reg_wr), .i_id_mem_rd(id_mem_rd),
    .i_id_mem_wr(id_mem_wr), .i_exm_reg_wr(exm_reg_wr), .i_exm_rd_idx(exm_rd_idx),
    .i_exm_res(exm_res), .i_exm_mem_rd(exm_mem_rd), .i_wb_reg_wr(wb_reg_wr),
    .i_wb_rd_idx(wb_rd_idx), .i_wb_data(wb_data), .o_hazard_stall(hazard_stall),
    .o_ex_valid(ex_valid), .o_ex_opcode(ex_opcode), .o_ex_funct(ex_funct), .o_ex_pc(ex_pc),
    .o_ex_imm(ex_imm), .o_ex_rs(ex_rs), .o_ex_rt(ex_rt), .o_ex_rd_idx(ex_rd_idx),
    .o_ex_reg_wr(ex_reg_wr), .o_ex_mem_rd(ex_mem_rd), .o_ex_mem_wr(ex_mem_wr)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  op;
    logic [1:0]  funct;
    logic [15:0] pc;
    logic [7:0]  imm;
    logic [2:0]  rd, rs, rt;
    logic        rs_used, rt_used, reg_wr, mem_rd, mem_wr;
    logic [15:0] rs_lat, rt_lat;
  } slot_t;

  slot_t ex_m;
  slot_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic slot_t reset_slot();
    slot_t s;
    s = '{default: '0};
    s.op = OP_NOP;
    return s;
  endfunction

  function automatic logic reads(input logic [2:0] r);
    return (id_rs_used && id_rs_idx == r) || (id_rt_used && id_rt_idx == r);
  endfunction

  function automatic logic model_hazard();
    logic h;
    h = ex_m.valid && ex_m.mem_rd && reads(ex_m.rd);
`ifndef ID_EX_FWD_EN
    h = h || (ex_m.reg_wr && reads(ex_m.rd)) || (exm_reg_wr && reads(exm_rd_idx)) ||
        (wb_reg_wr && reads(wb_rd_idx));
`endif
    return h && id_valid && !flush;
  endfunction

  // Value the ALU should see for a source given what the later stages are writing right now
  function automatic logic [15:0] operand(input logic [2:0] idx, input logic used, input logic [15:0] lat);
`ifdef ID_EX_FWD_EN
    if (used && exm_reg_wr && !exm_mem_rd && exm_rd_idx == idx) return exm_res;
    if (used && wb_reg_wr && wb_rd_idx == idx) return wb_data;
`endif
    return lat;
  endfunction

  task automatic step();
    logic hz;
    #1;
    hz = model_hazard();
    chk("hazard_stall", hazard_stall, hz);
    if (flush || (!stall && hz)) begin
      ex_m.valid = 0; ex_m.op = OP_NOP; ex_m.reg_wr = 0; ex_m.mem_rd = 0; ex_m.mem_wr = 0;
    end else if (!stall) begin
      ex_m.valid = id_valid; ex_m.op = id_opcode; ex_m.funct = id_funct; ex_m.pc = id_pc;
      ex_m.imm = id_imm; ex_m.rd = id_rd_idx; ex_m.rs = id_rs_idx; ex_m.rt = id_rt_idx;
      ex_m.rs_used = id_rs_used; ex_m.rt_used = id_rt_used; ex_m.reg_wr = id_reg_wr;
      ex_m.mem_rd = id_mem_rd; ex_m.mem_wr = id_mem_wr;
      ex_m.rs_lat = (wb_reg_wr && wb_rd_idx == id_rs_idx) ? wb_data : id_rs_data;
      ex_m.rt_lat = (wb_reg_wr && wb_rd_idx == id_rt_idx) ? wb_data : id_rt_data;
    end
    exp_q.push_back(ex_m);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic rsu, input logic rtu,
                       input logic rw, input logic mr);
    id_valid = 1; id_opcode = op; id_funct = 2'($urandom_range(0, 3));
    id_rd_idx = rd; id_rs_idx = rs; id_rt_idx = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_reg_wr = rw; id_mem_rd = mr; id_mem_wr = 0;
    id_rs_data = 16'($urandom); id_rt_data = 16'($urandom);
    id_pc = 16'($urandom); id_imm = 8'($urandom);
  endtask

  task automatic idle_id();
    id_valid = 0; id_opcode = OP_NOP; id_funct = 0; id_rd_idx = 0; id_rs_idx = 0; id_rt_idx = 0;
    id_rs_used = 0; id_rt_used = 0; id_reg_wr = 0; id_mem_rd = 0; id_mem_wr = 0;
    id_rs_data = 0; id_rt_data = 0; id_pc = 0; id_imm = 0;
  endtask

  task automatic idle_fwd();
    exm_reg_wr = 0; exm_mem_rd = 0; exm_rd_idx = 0; exm_res = 0;
    wb_reg_wr = 0; wb_rd_idx = 0; wb_data = 0;
  endtask

  // Monitor: one expected slot per edge; stalls repeat the previous slot
  initial begin : monitor
    slot_t cur;
    int    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("queue_depth", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          n++;
          $display("txn %0d t=%0t v=%0b op=%h pc=%h rs=%h rt=%h rd=%0d wr=%0b", n, $time,
                   ex_valid, ex_opcode, ex_pc, ex_rs, ex_rt, ex_rd_idx, ex_reg_wr);
          chk("ex_valid", ex_valid, cur.valid);
          chk("ex_opcode", ex_opcode, cur.op);
          chk("ex_reg_wr", ex_reg_wr, cur.reg_wr);
          chk("ex_mem_rd", ex_mem_rd, cur.mem_rd);
          chk("ex_mem_wr", ex_mem_wr, cur.mem_wr);
          if (cur.valid) begin
            chk("ex_funct", ex_funct, cur.funct);
            chk("ex_pc", ex_pc, cur.pc);
            chk("ex_imm", ex_imm, cur.imm);
            chk("ex_rd_idx", ex_rd_idx, cur.rd);
            chk("ex_rs", ex_rs, operand(cur.rs, cur.rs_used, cur.rs_lat));
            chk("ex_rt", ex_rt, operand(cur.rt, cur.rt_used, cur.rt_lat));
          end
        end
      end
    end
  end

  initial begin : driver
    int cnt;
    stall = 0; flush = 0;
    idle_id();
    idle_fwd();
    ex_m = reset_slot();
    repeat (2) @(negedge clk);
    chk("rst_valid", ex_valid, 0);
    chk("rst_opcode", ex_opcode, OP_NOP);
    chk("rst_reg_wr", ex_reg_wr, 0);
    chk("rst_mem_rd", ex_mem_rd, 0);
    chk("rst_rs", ex_rs, 0);
    chk("rst_rt", ex_rt, 0);
    chk("rst_pc", ex_pc, 0);
    rst = 0;
    mon_en = 1;

`ifdef ID_EX_FWD_EN
    // ADD R3 then SUB R3: EX/MEM forward
    step();
    issue(OP_ALU_R, 3, 1, 2, 1, 1, 1, 0); step();
    issue(OP_ALU_R, 4, 3, 1, 1, 1, 1, 0);
    #1 chk("t2_hazard", hazard_stall, 0);
    step();
    idle_id(); exm_reg_wr = 1; exm_rd_idx = 3; exm_res = 16'h1234;
    #1 chk("t2_fwd_rs", ex_rs, 16'h1234);
    step();
    idle_fwd();

    // LD R2 then ADD R2: one bubble, then MEM/WB forward
    step();
    issue(OP_LD, 2, 1, 0, 1, 0, 1, 1); step();
    issue(OP_ALU_R, 5, 2, 1, 1, 1, 1, 0);
    #1 chk("t3_hazard_on", hazard_stall, 1);
    step();
    exm_reg_wr = 1; exm_mem_rd = 1; exm_rd_idx = 2; exm_res = 16'h5555;
    #1 chk("t3_hazard_off", hazard_stall, 0);
    step();
    idle_id(); idle_fwd(); wb_reg_wr = 1; wb_rd_idx = 2; wb_data = 16'hBEEF;
    #1 chk("t3_valid", ex_valid, 1);
    chk("t3_fwd_rs", ex_rs, 16'hBEEF);
    step();
    idle_fwd();

    // Both later stages write R5: EX/MEM wins
    step();
    issue(OP_ALU_R, 6, 1, 5, 1, 1, 1, 0); step();
    idle_id(); exm_reg_wr = 1; exm_rd_idx = 5; exm_res = 16'h0001;
    wb_reg_wr = 1; wb_rd_idx = 5; wb_data = 16'h0002;
    #1 chk("t4_fwd_rt", ex_rt, 16'h0001);
    step();
    idle_fwd();
`else
    // Back-to-back dependent ADDs stall until the producer has left writeback
    step();
    issue(OP_ALU_R, 4, 1, 2, 1, 1, 1, 0); step();
    issue(OP_ALU_R, 5, 4, 1, 1, 1, 1, 0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      idle_fwd();
      if (c == 1) begin exm_reg_wr = 1; exm_rd_idx = 4; end
      if (c == 2) begin wb_reg_wr = 1; wb_rd_idx = 4; end
      #1 if (hazard_stall) cnt++;
      step();
    end
    chk("t6_stall_cycles", cnt, 3);
    chk("t6_captured", ex_valid, 1);
    idle_id(); idle_fwd();
`endif

    // Write-through: register written in the same cycle it is read
    step();
    issue(OP_ADDI, 7, 6, 0, 0, 0, 1, 0);
    id_rs_data = 16'h0000; wb_reg_wr = 1; wb_rd_idx = 6; wb_data = 16'hCAFE;
    step();
    idle_id(); idle_fwd();
    #1 chk("wt_rs", ex_rs, 16'hCAFE);
    step();

    // stall+flush on the same edge loads a bubble; stall alone holds everything
    issue(OP_ALU_R, 7, 1, 2, 1, 1, 1, 0); step();
    stall = 1; flush = 1;
    issue(OP_ALU_R, 3, 1, 2, 1, 1, 1, 0); step();
    #1 chk("t5_flush_valid", ex_valid, 0);
    chk("t5_flush_op", ex_opcode, OP_NOP);
    stall = 0; flush = 0;
    issue(OP_ADDI, 6, 1, 2, 1, 0, 1, 0); id_pc = 16'h0100; step();
    stall = 1;
    issue(OP_ALU_R, 5, 6, 6, 1, 1, 1, 0); id_pc = 16'h0200;
    for (int c = 0; c < 3; c++) begin
      step();
      #1 chk("t5_hold_pc", ex_pc, 16'h0100);
      chk("t5_hold_op", ex_opcode, OP_ADDI);
      chk("t5_hold_valid", ex_valid, 1);
    end
    stall = 0;
    idle_id(); step();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) != 0) begin
        issue(5'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
        id_mem_wr = 1'($urandom);
      end else begin
        idle_id();
      end
      exm_reg_wr = 1'($urandom); exm_mem_rd = ($urandom_range(0, 3) == 0);
      exm_rd_idx = 3'($urandom); exm_res = 16'($urandom);
      wb_reg_wr = 1'($urandom); wb_rd_idx = 3'($urandom); wb_data = 16'($urandom);
      step();
    end
    stall = 0; flush = 0;
    idle_id(); idle_fwd();
    step();

    // Asynchronous reset between edges
    issue(OP_ALU_R, 1, 0, 0, 0, 0, 1, 0); step();
    idle_id();
    mon_en = 0;
    chk("t1_pre_valid", ex_valid, 1);
    #2 rst = 1;
    #1 chk("t1_async_valid", ex_valid, 0);
    chk("t1_async_opcode", ex_opcode, 5'b00001);
    chk("t1_async_reg_wr", ex_reg_wr, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
